// File: rtl/xmodem_loader_if.sv
// UART and IMEM signals seen by the XMODEM program loader.
// The master modport is the loader side; the slave modport is the UART FIFOs and IMEM side.
interface xmodem_loader_if #(
  parameter int NB_UART_DATA    = 8,
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7
);
  // UART RX FIFO (first-word-fall-through head byte)
  logic                       rx_empty;
  logic [NB_UART_DATA-1:0]    rx_data;
  logic                       rx_rd;
  // UART TX path
  logic                       tx_wr;
  logic [NB_UART_DATA-1:0]    tx_data;
  logic                       tx_start;
  logic                       tx_done;
  // Instruction memory write port
  logic                       imem_wr;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic [NB_INSTRUCTION-1:0]  imem_data;

  modport master (
    input  rx_empty, rx_data, tx_done,
    output rx_rd, tx_wr, tx_data, tx_start, imem_wr, imem_addr, imem_data
  );

  modport slave (
    output rx_empty, rx_data, tx_done,
    input  rx_rd, tx_wr, tx_data, tx_start, imem_wr, imem_addr, imem_data
  );
endinterface

// File: rtl/xmodem_loader.sv
// XMODEM-checksum program loader: receives 128-byte blocks from the UART RX FIFO,
// packs every 4 bytes into a little-endian instruction word written to IMEM,
// and answers each block or EOT with ACK/NAK on the UART TX path.
module xmodem_loader #(
  parameter int NB_UART_DATA    = 8,
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_en,
  xmodem_loader_if.master bus,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_overflow
);
  localparam int NB          = NB_UART_DATA;
  localparam int NI          = NB_INSTRUCTION;
  localparam int AW          = IMEM_ADDR_WIDTH;
  localparam int BPW         = NI / NB;
  localparam int WIW         = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BLOCK_BYTES = 128;

  localparam logic [NB-1:0] SOH = NB'(8'h01);
  localparam logic [NB-1:0] EOT = NB'(8'h04);
  localparam logic [NB-1:0] ACK = NB'(8'h06);
  localparam logic [NB-1:0] NAK = NB'(8'h15);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_SOH, S_BLK, S_BLK_N, S_DATA, S_CKSUM,
    S_SEND_WR, S_SEND_START, S_SEND_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   expect_q, expect_d;     // next block number to accept
  logic [NB-1:0]   blk_q, blk_d;
  logic [NB-1:0]   blkn_q, blkn_d;
  logic [NB-1:0]   sum_q, sum_d;
  logic [6:0]      cnt_q, cnt_d;           // data byte index within the block
  logic [WIW-1:0]  widx_q, widx_d;         // byte index within the word
  logic [NI-1:0]   word_q, word_d;
  logic [AW:0]     addr_q, addr_d;         // extra MSB flags "past end of IMEM"
  logic [AW:0]     base_q, base_d;         // address at BLK entry (rewind target)
  logic [AW:0]     last_base_q, last_base_d; // start of the last accepted block
  logic            ovf_q, ovf_d;
  logic            rd_q, rd_d;
  logic            imem_wr_q, imem_wr_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [NI-1:0]   imem_data_q, imem_data_d;
  logic [NB-1:0]   tx_byte_q, tx_byte_d;
  logic            eot_q, eot_d;

  logic            wants_byte, take, cmp_ok, sum_ok;

  // A byte is consumed only in receiving states, and never the cycle right after a pop
  // so the FIFO head has time to advance.
  assign wants_byte = state_q inside {S_WAIT_SOH, S_BLK, S_BLK_N, S_DATA, S_CKSUM};
  assign take       = wants_byte && i_en && !bus.rx_empty && !rd_q;

  assign bus.rx_rd     = take;
  assign bus.tx_wr     = (state_q == S_SEND_WR);
  assign bus.tx_start  = (state_q == S_SEND_START);
  assign bus.tx_data   = tx_byte_q;
  assign bus.imem_wr   = imem_wr_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.imem_data = imem_data_q;
  assign o_busy        = !(state_q inside {S_IDLE, S_DONE});
  assign o_done        = (state_q == S_DONE);
  assign o_overflow    = ovf_q;

  // Next-state and datapath decode for the whole loader.
  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    expect_d    = expect_q;
    blk_d       = blk_q;
    blkn_d      = blkn_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    base_d      = base_q;
    last_base_d = last_base_q;
    ovf_d       = ovf_q;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    tx_byte_d   = tx_byte_q;
    eot_d       = eot_q;
    imem_wr_d   = 1'b0;
    rd_d        = take;
    cmp_ok      = (blk_q == ~blkn_q);
    sum_ok      = (bus.rx_data == sum_q);

    unique case (state_q)
      S_IDLE: begin
        expect_d    = NB'(1);
        sum_d       = '0;
        cnt_d       = '0;
        widx_d      = '0;
        addr_d      = '0;
        base_d      = '0;
        last_base_d = '0;
        ovf_d       = 1'b0;
        eot_d       = 1'b0;
        if (i_en) state_d = S_WAIT_SOH;
      end
      S_WAIT_SOH: if (take) begin
        if (bus.rx_data == SOH) begin
          base_d  = addr_q;
          state_d = S_BLK;
        end else if (bus.rx_data == EOT) begin
          tx_byte_d = ACK;
          eot_d     = 1'b1;
          state_d   = S_SEND_WR;
        end
      end
      S_BLK: if (take) begin
        blk_d = bus.rx_data;
        // A likely retransmit of the accepted block is written over that block's words.
        if (bus.rx_data == expect_q - NB'(1)) addr_d = last_base_q;
        state_d = S_BLK_N;
      end
      S_BLK_N: if (take) begin
        blkn_d  = bus.rx_data;
        sum_d   = '0;
        cnt_d   = '0;
        widx_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: if (take) begin
        sum_d  = sum_q + bus.rx_data;
        word_d = {bus.rx_data, word_q[NI-1:NB]};
        cnt_d  = cnt_q + 7'd1;
        widx_d = widx_q + WIW'(1);
        if (widx_q == WIW'(BPW - 1)) begin
          widx_d = '0;
          if (addr_q[AW]) begin
            ovf_d = 1'b1;
          end else begin
            imem_wr_d   = 1'b1;
            imem_addr_d = addr_q[AW-1:0];
            imem_data_d = word_d;
            addr_d      = addr_q + 1'b1;
          end
        end
        if (cnt_q == 7'(BLOCK_BYTES - 1)) state_d = S_CKSUM;
      end
      S_CKSUM: if (take) begin
        eot_d   = 1'b0;
        state_d = S_SEND_WR;
        if (cmp_ok && sum_ok && blk_q == expect_q) begin
          expect_d    = expect_q + NB'(1);
          last_base_d = base_q;
          tx_byte_d   = ACK;
        end else if (cmp_ok && sum_ok && blk_q == expect_q - NB'(1)) begin
          addr_d    = base_q;
          tx_byte_d = ACK;
        end else begin
          addr_d    = base_q;
          tx_byte_d = NAK;
        end
      end
      S_SEND_WR:    state_d = S_SEND_START;
      S_SEND_START: state_d = S_SEND_WAIT;
      S_SEND_WAIT:  if (bus.tx_done) state_d = eot_q ? S_DONE : S_WAIT_SOH;
      S_DONE:       if (!i_en) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // Disarming aborts any transfer in progress.
    if (!i_en && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_IDLE;
      imem_wr_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      expect_q    <= NB'(1);
      blk_q       <= '0;
      blkn_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      last_base_q <= '0;
      ovf_q       <= 1'b0;
      rd_q        <= 1'b0;
      imem_wr_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      tx_byte_q   <= '0;
      eot_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      expect_q    <= expect_d;
      blk_q       <= blk_d;
      blkn_q      <= blkn_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      last_base_q <= last_base_d;
      ovf_q       <= ovf_d;
      rd_q        <= rd_d;
      imem_wr_q   <= imem_wr_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      tx_byte_q   <= tx_byte_d;
      eot_q       <= eot_d;
    end
  end
endmodule

// File: tb/tb_xmodem_loader.sv
// Self-checking bench for xmodem_loader: models the UART RX FIFO and TX completion,
// scoreboards expected IMEM writes and ACK/NAK bytes, and runs a table of blocks.
module tb_xmodem_loader;
  localparam int AW = 7;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic busy, done, ovf;

  xmodem_loader_if #(.NB_UART_DATA(8), .NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(AW)) bus ();

  xmodem_loader #(.NB_UART_DATA(8), .NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .i_rst      (rst),
    .i_en       (en),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0] blk;
    logic [7:0] blkn;
    logic [7:0] sum_adj;
    logic [7:0] seed;     // 0 selects the program image
    int         base;     // first expected word address, -1 for no writes
    logic [7:0] resp;
    logic       ovf;
  } vec_t;

  logic [7:0]  rx_fifo[$];
  wr_t         exp_wr[$];
  logic [7:0]  exp_resp[$];
  logic [7:0]  blk_bytes[128];
  logic [31:0] prog[20];
  int          tx_cnt = 0;
  logic        tx_pending = 1'b0;
  logic        last_tx_wr = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic update_rx();
    bus.rx_empty = (rx_fifo.size() == 0);
    bus.rx_data  = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_fifo.push_back(b);
    update_rx();
  endtask

  // One clock: sample DUT outputs on the falling edge, update the FIFO/TX models after the rising edge.
  task automatic step();
    logic pop;
    @(negedge clk);
    pop = bus.rx_rd;
    if (bus.imem_wr) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        $display("FAIL imem_wr: got write addr=%0d data=0x%08h expected none", bus.imem_addr, bus.imem_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("imem_data", bus.imem_data, e.data);
      end
    end
    if (bus.tx_start) begin
      check("tx_start_after_wr", 32'(last_tx_wr), 32'd1);
      tx_cnt = 3;
    end
    if (bus.tx_wr) begin
      tx_pending = 1'b1;
      if (exp_resp.size() == 0) begin
        n_checks++;
        $display("FAIL tx_resp: got 0x%02h expected none", bus.tx_data);
      end else begin
        check("tx_resp", 32'(bus.tx_data), 32'(exp_resp.pop_front()));
      end
    end
    last_tx_wr = bus.tx_wr;
    @(posedge clk);
    #1;
    if (pop && rx_fifo.size() != 0) rx_fifo.delete(0);
    bus.tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        bus.tx_done = 1'b1;
        tx_pending  = 1'b0;
      end
    end
    update_rx();
  endtask

  task automatic run_until_quiet(input string name);
    int k;
    k = 0;
    while (k < 3000 && (rx_fifo.size() != 0 || exp_resp.size() != 0 || tx_pending || bus.tx_done)) begin
      step();
      k++;
    end
    if (k == 3000) begin
      n_checks++;
      $display("FAIL %s timeout: fifo=%0d pending_resp=%0d expected all drained", name, rx_fifo.size(), exp_resp.size());
    end
  endtask

  task automatic build_block(input logic [7:0] seed);
    for (int i = 0; i < 128; i++) begin
      logic [31:0] w;
      w = prog[i/4];
      if (seed == 8'h00) blk_bytes[i] = (i < 80) ? w[8*(i%4) +: 8] : 8'h1A;
      else               blk_bytes[i] = 8'(int'(seed) + i * 3);
    end
  endtask

  // Push SOH/blk/~blk and n_data bytes; a full block also gets its checksum and expected reply.
  task automatic queue_block(input logic [7:0] blk, input logic [7:0] blkn, input logic [7:0] sum_adj,
                             input int base, input logic [7:0] resp, input int n_data);
    logic [7:0] s;
    s = 8'h00;
    push_byte(SOH);
    push_byte(blk);
    push_byte(blkn);
    for (int i = 0; i < n_data; i++) begin
      push_byte(blk_bytes[i]);
      s = s + blk_bytes[i];
    end
    if (base >= 0) begin
      for (int w = 0; w < n_data / 4; w++) begin
        wr_t e;
        e.addr = AW'(base + w);
        e.data = {blk_bytes[4*w+3], blk_bytes[4*w+2], blk_bytes[4*w+1], blk_bytes[4*w]};
        exp_wr.push_back(e);
      end
    end
    if (n_data == 128) begin
      push_byte(s + sum_adj);
      exp_resp.push_back(resp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
    check({tag, "_ovf"},       32'(ovf),           32'd0);
    check({tag, "_rx_rd"},     32'(bus.rx_rd),     32'd0);
    check({tag, "_tx_wr"},     32'(bus.tx_wr),     32'd0);
    check({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
    check({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    check({tag, "_imem_wr"},   32'(bus.imem_wr),   32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_imem_data"}, bus.imem_data,      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{32'h00108093, 32'h00210113, 32'h00318193, 32'h00420213, 32'h00528293,
             32'h00630313, 32'h00738393, 32'h00840413, 32'h00948493, 32'h00a50513,
             32'h002081b3, 32'h40208233, 32'h0020f2b3, 32'h0020e333, 32'h0020c3b3,
             32'h00209433, 32'h0020d4b3, 32'h00102023, 32'h00202223, 32'h00302423};
    //           blk    ~blk   adj    seed   base resp ovf
    vecs[0] = '{8'h01, 8'hFF, 8'h00, 8'h10,   0, NAK, 1'b0}; // bad complement
    vecs[1] = '{8'h01, 8'hFE, 8'h01, 8'h20,   0, NAK, 1'b0}; // bad checksum
    vecs[2] = '{8'h01, 8'hFE, 8'h00, 8'h30,   0, ACK, 1'b0}; // block 1 accepted
    vecs[3] = '{8'h01, 8'hFE, 8'h00, 8'h40,   0, ACK, 1'b0}; // duplicate rewrites 0..31
    vecs[4] = '{8'h02, 8'hFD, 8'h00, 8'h50,  32, ACK, 1'b0};
    vecs[5] = '{8'h04, 8'hFB, 8'h00, 8'h60,  64, NAK, 1'b0}; // out of sequence
    vecs[6] = '{8'h03, 8'hFC, 8'h00, 8'h70,  64, ACK, 1'b0};
    vecs[7] = '{8'h04, 8'hFB, 8'h00, 8'h80,  96, ACK, 1'b0}; // fills up to 127
    vecs[8] = '{8'h05, 8'hFA, 8'h00, 8'h90,  -1, ACK, 1'b1}; // past IMEM: no writes

    rst = 1'b1;
    en  = 1'b0;
    bus.tx_done = 1'b0;
    update_rx();
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Program image then EOT; a junk byte before SOH is dropped and EOT waits in the FIFO during the ACK.
    push_byte(8'h55);
    build_block(8'h00);
    queue_block(8'h01, 8'hFE, 8'h00, 0, ACK, 128);
    push_byte(EOT);
    exp_resp.push_back(ACK);
    run_until_quiet("prog_load");
    step();
    step();
    check("prog_done",   32'(done),           32'd1);
    check("prog_busy",   32'(busy),           32'd0);
    check("prog_writes", 32'(exp_wr.size()),  32'd0);
    en = 1'b0;
    step();
    step();
    check("disarm_done", 32'(done), 32'd0);
    en = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      build_block(vecs[v].seed);
      queue_block(vecs[v].blk, vecs[v].blkn, vecs[v].sum_adj, vecs[v].base, vecs[v].resp, 128);
      run_until_quiet($sformatf("vec%0d", v));
      step();
      check($sformatf("vec%0d_ovf", v),    32'(ovf),          32'(vecs[v].ovf));
      check($sformatf("vec%0d_writes", v), 32'(exp_wr.size()), 32'd0);
    end

    // Re-arming clears the sticky overflow; then reset is asserted in the middle of a block.
    en = 1'b0;
    step();
    step();
    check("rearm_ovf",  32'(ovf),  32'd0);
    check("rearm_busy", 32'(busy), 32'd0);
    en = 1'b1;
    step();
    build_block(8'hA0);
    queue_block(8'h01, 8'hFE, 8'h00, 0, ACK, 50);
    run_until_quiet("partial");
    step();
    step();
    check("partial_busy",   32'(busy),          32'd1);
    check("partial_writes", 32'(exp_wr.size()), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    step();
    step();
    rst = 1'b0;
    rx_fifo.delete();
    update_rx();
    step();
    build_block(8'h00);
    queue_block(8'h01, 8'hFE, 8'h00, 0, ACK, 128);
    push_byte(EOT);
    exp_resp.push_back(ACK);
    run_until_quiet("reload");
    step();
    step();
    check("reload_done",   32'(done),          32'd1);
    check("reload_writes", 32'(exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
